// File: rtl/config_ctx_regfile.sv
// rtl/config_ctx_regfile.sv - multi-context lane register file for the CGRA tile config memory
// Masked loader writes over valid/ready, registered read of the active context, lock and switch control.
module config_ctx_regfile #(
   parameter int WIDTH     = 16,
   parameter int NUM_LANES = 9,
   parameter int NUM_CTX   = 4,
   localparam int CTX_W    = $clog2(NUM_CTX)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [CTX_W-1:0]     wr_ctx,
   input  logic [NUM_LANES-1:0] wr_mask,
   input  logic [WIDTH-1:0]     w_data [NUM_LANES],
   input  logic                 lock,
   output logic                 wr_ack,
   output logic                 wr_err,
   input  logic                 sw_req,
   input  logic [CTX_W-1:0]     sw_ctx,
   output logic                 sw_done,
   output logic [CTX_W-1:0]     active_ctx,
   output logic [WIDTH-1:0]     r_data [NUM_LANES],
   output logic [NUM_CTX-1:0]   ctx_valid
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_ACK, S_SW, S_SWD} state_t;

   state_t               state;
   logic [WIDTH-1:0]     mem     [NUM_CTX][NUM_LANES];
   logic [NUM_LANES-1:0] written [NUM_CTX];
   logic [CTX_W-1:0]     cap_ctx;
   logic [NUM_LANES-1:0] cap_mask;
   logic [WIDTH-1:0]     cap_data [NUM_LANES];
   logic                 refuse;

   assign wr_ready = (state == S_IDLE) && !reset;

   always_comb begin
      ctx_valid = '0;
      for (int c = 0; c < NUM_CTX; c++)
         ctx_valid[c] = &written[c];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         active_ctx <= '0;
         wr_ack     <= 1'b0;
         wr_err     <= 1'b0;
         sw_done    <= 1'b0;
         cap_ctx    <= '0;
         cap_mask   <= '0;
         refuse     <= 1'b0;
         for (int c = 0; c < NUM_CTX; c++) begin
            written[c] <= '0;
            for (int l = 0; l < NUM_LANES; l++)
               mem[c][l] <= '0;
         end
         for (int l = 0; l < NUM_LANES; l++) begin
            r_data[l]   <= '0;
            cap_data[l] <= '0;
         end
      end else begin
         wr_ack  <= 1'b0;
         wr_err  <= 1'b0;
         sw_done <= 1'b0;
         for (int l = 0; l < NUM_LANES; l++)
            r_data[l] <= mem[active_ctx][l];

         case (state)
            S_IDLE: begin
               // A pending write wins; sw_req is a level and is picked up on a later IDLE cycle.
               if (wr_valid) begin
                  cap_ctx  <= wr_ctx;
                  cap_mask <= wr_mask;
                  for (int l = 0; l < NUM_LANES; l++)
                     cap_data[l] <= w_data[l];
                  refuse <= lock && (wr_ctx == active_ctx);
                  state  <= S_WR;
               end else if (sw_req) begin
                  active_ctx <= sw_ctx;
                  state      <= S_SW;
               end
            end
            S_WR: begin
               if (!refuse) begin
                  for (int l = 0; l < NUM_LANES; l++)
                     if (cap_mask[l])
                        mem[cap_ctx][l] <= cap_data[l];
                  written[cap_ctx] <= written[cap_ctx] | cap_mask;
               end
               wr_ack <= !refuse;
               wr_err <= refuse;
               state  <= S_ACK;
            end
            S_ACK: state <= S_IDLE;
            S_SW: begin
               sw_done <= 1'b1;
               state   <= S_SWD;
            end
            S_SWD:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_config_ctx_regfile.sv
// tb/tb_config_ctx_regfile.sv - self-checking bench for config_ctx_regfile
// Directed vector table, hand sequences for switch/overlap/reset, and random ops against a transaction model.
module tb_config_ctx_regfile;
   localparam int WIDTH = 16;
   localparam int NL    = 9;
   localparam int NC    = 4;
   localparam int CW    = 2;

   logic             clk = 1'b0;
   logic             reset, wr_valid, wr_ready, lock, wr_ack, wr_err, sw_req, sw_done;
   logic [CW-1:0]    wr_ctx, sw_ctx, active_ctx;
   logic [NL-1:0]    wr_mask;
   logic [WIDTH-1:0] w_data [NL];
   logic [WIDTH-1:0] r_data [NL];
   logic [NC-1:0]    ctx_valid;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] m_mem [NC][NL];
   bit               m_wr  [NC][NL];
   int               m_active;

   always #5 clk = ~clk;

   config_ctx_regfile #(.WIDTH(WIDTH), .NUM_LANES(NL), .NUM_CTX(NC)) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ctx(wr_ctx),
      .wr_mask(wr_mask), .w_data(w_data), .lock(lock), .wr_ack(wr_ack), .wr_err(wr_err),
      .sw_req(sw_req), .sw_ctx(sw_ctx), .sw_done(sw_done), .active_ctx(active_ctx),
      .r_data(r_data), .ctx_valid(ctx_valid)
   );

   typedef struct {
      int               ctx;
      logic [NL-1:0]    mask;
      bit               lk;
      logic [NL*WIDTH-1:0] data;
      bit               exp_ack;
      logic [WIDTH-1:0] exp_r0;
      logic [WIDTH-1:0] exp_r8;
      logic [NC-1:0]    exp_valid;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_active = 0;
      for (int c = 0; c < NC; c++)
         for (int l = 0; l < NL; l++) begin
            m_mem[c][l] = '0;
            m_wr[c][l]  = 1'b0;
         end
   endtask

   function automatic logic [NC-1:0] m_valid();
      logic [NC-1:0] v;
      for (int c = 0; c < NC; c++) begin
         v[c] = 1'b1;
         for (int l = 0; l < NL; l++)
            if (!m_wr[c][l]) v[c] = 1'b0;
      end
      return v;
   endfunction

   task automatic chk_rdata(input string name);
      for (int l = 0; l < NL; l++)
         chk($sformatf("%s[%0d]", name, l), r_data[l], m_mem[m_active][l]);
   endtask

   task automatic do_write(input int ctx, input logic [NL-1:0] mask, input logic [NL*WIDTH-1:0] data,
                           input bit lk, output bit got_ack, output bit got_err);
      int budget = 0;
      bit refuse;
      while (!wr_ready && budget < 10) begin
         step();
         budget++;
      end
      chk("wr_ready_before_write", wr_ready, 1);
      wr_valid = 1'b1;
      wr_ctx   = CW'(ctx);
      wr_mask  = mask;
      lock     = lk;
      for (int l = 0; l < NL; l++) w_data[l] = data[l*WIDTH +: WIDTH];
      refuse = lk && (ctx == m_active);
      step();
      wr_valid = 1'b0;
      lock     = 1'b0;
      chk("wr_ready_in_wr", wr_ready, 0);
      chk("wr_ack_early", wr_ack, 0);
      step();
      got_ack = wr_ack;
      got_err = wr_err;
      chk("wr_ack", wr_ack, !refuse);
      chk("wr_err", wr_err, refuse);
      chk("wr_ready_in_ack", wr_ready, 0);
      if (!refuse)
         for (int l = 0; l < NL; l++)
            if (mask[l]) begin
               m_mem[ctx][l] = data[l*WIDTH +: WIDTH];
               m_wr[ctx][l]  = 1'b1;
            end
      chk("ctx_valid_e1", ctx_valid, m_valid());
      step();
      chk("wr_ready_after_write", wr_ready, 1);
      chk("wr_ack_cleared", wr_ack | wr_err, 0);
      chk_rdata("r_data_after_write");
   endtask

   task automatic do_switch(input int ctx);
      sw_req = 1'b1;
      sw_ctx = CW'(ctx);
      step();
      sw_req   = 1'b0;
      m_active = ctx;
      chk("active_ctx_e0", active_ctx, ctx);
      chk("sw_done_e0", sw_done, 0);
      chk("wr_ready_in_sw", wr_ready, 0);
      step();
      chk("sw_done_e1", sw_done, 1);
      chk("wr_ready_in_swd", wr_ready, 0);
      chk_rdata("r_data_after_switch");
      step();
      chk("sw_done_e2", sw_done, 0);
      chk("wr_ready_after_switch", wr_ready, 1);
   endtask

   function automatic logic [NL*WIDTH-1:0] rand_data();
      logic [NL*WIDTH-1:0] d;
      for (int l = 0; l < NL; l++) d[l*WIDTH +: WIDTH] = WIDTH'($urandom);
      return d;
   endfunction

   initial begin
      vec_t vecs [5];
      bit   ga, ge;
      logic [NL*WIDTH-1:0] d;

      vecs[0] = '{0, 9'h1FF, 1'b0, {16'h9999, 16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444,
                 16'h3333, 16'h2222, 16'h1111}, 1'b1, 16'h1111, 16'h9999, 4'b0001};
      vecs[1] = '{0, 9'h109, 1'b0, {16'hCCCC, 16'h0, 16'h0, 16'h0, 16'h0, 16'hBBBB, 16'h0, 16'h0,
                 16'hAAAA}, 1'b1, 16'hAAAA, 16'hCCCC, 4'b0001};
      vecs[2] = '{0, 9'h001, 1'b1, {128'h0, 16'hDDDD}, 1'b0, 16'hAAAA, 16'hCCCC, 4'b0001};
      vecs[3] = '{1, 9'h001, 1'b1, {128'h0, 16'hDDDD}, 1'b1, 16'hAAAA, 16'hCCCC, 4'b0001};
      vecs[4] = '{0, 9'h000, 1'b0, {NL*WIDTH{1'b1}}, 1'b1, 16'hAAAA, 16'hCCCC, 4'b0001};

      reset = 1'b1; wr_valid = 1'b0; lock = 1'b0; sw_req = 1'b0;
      wr_ctx = '0; sw_ctx = '0; wr_mask = '0;
      for (int l = 0; l < NL; l++) w_data[l] = '0;
      model_reset();
      step(); step(); step();
      chk("reset_wr_ready", wr_ready, 0);
      chk("reset_pulses", {wr_ack, wr_err, sw_done}, 0);
      reset = 1'b0;
      step();
      chk("post_reset_wr_ready", wr_ready, 1);
      chk("post_reset_active", active_ctx, 0);
      chk("post_reset_ctx_valid", ctx_valid, 0);
      chk_rdata("post_reset_r_data");

      for (int i = 0; i < 5; i++) begin
         do_write(vecs[i].ctx, vecs[i].mask, vecs[i].data, vecs[i].lk, ga, ge);
         chk($sformatf("vec%0d_ack", i), ga, vecs[i].exp_ack);
         chk($sformatf("vec%0d_err", i), ge, !vecs[i].exp_ack);
         chk($sformatf("vec%0d_r0", i), r_data[0], vecs[i].exp_r0);
         chk($sformatf("vec%0d_r8", i), r_data[8], vecs[i].exp_r8);
         chk($sformatf("vec%0d_valid", i), ctx_valid, vecs[i].exp_valid);
      end

      do_write(2, 9'h1FF, rand_data(), 1'b0, ga, ge);
      do_switch(2);
      chk("ctx2_valid_bit", ctx_valid[2], 1);
      chk("ctx_valid_after_fill", ctx_valid, 4'b0101);

      // write and switch requested in the same IDLE cycle
      d = rand_data();
      wr_valid = 1'b1; wr_ctx = 2'd3; wr_mask = '1; lock = 1'b0;
      for (int l = 0; l < NL; l++) w_data[l] = d[l*WIDTH +: WIDTH];
      sw_req = 1'b1; sw_ctx = 2'd0;
      step();
      wr_valid = 1'b0;
      chk("ovl_wr_ready_wr", wr_ready, 0);
      chk("ovl_active_held", active_ctx, 2);
      step();
      chk("ovl_wr_ack", wr_ack, 1);
      chk("ovl_wr_ready_ack", wr_ready, 0);
      chk("ovl_no_sw_done", sw_done, 0);
      for (int l = 0; l < NL; l++) begin
         m_mem[3][l] = d[l*WIDTH +: WIDTH];
         m_wr[3][l]  = 1'b1;
      end
      step();
      step();
      sw_req   = 1'b0;
      m_active = 0;
      chk("ovl_active_switched", active_ctx, 0);
      chk("ovl_wr_ready_sw", wr_ready, 0);
      step();
      chk("ovl_sw_done", sw_done, 1);
      chk("ovl_wr_ready_swd", wr_ready, 0);
      chk_rdata("ovl_r_data");
      step();
      chk("ovl_wr_ready_end", wr_ready, 1);
      chk("ovl_ctx_valid", ctx_valid, m_valid());

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0)
            do_switch(int'($urandom_range(0, NC-1)));
         else
            do_write(int'($urandom_range(0, NC-1)), NL'($urandom), rand_data(),
                     bit'($urandom_range(0, 1)), ga, ge);
         chk("rand_ctx_valid", ctx_valid, m_valid());
         chk("rand_active", active_ctx, m_active);
      end

      // reset while a captured write sits in WR
      wr_valid = 1'b1; wr_ctx = CW'(m_active); wr_mask = '1; lock = 1'b0;
      for (int l = 0; l < NL; l++) w_data[l] = 16'h5A5A;
      step();
      wr_valid = 1'b0;
      reset    = 1'b1;
      step();
      chk("rst_wr_no_ack", wr_ack, 0);
      chk("rst_wr_ready", wr_ready, 0);
      for (int l = 0; l < NL; l++) chk($sformatf("rst_r_data[%0d]", l), r_data[l], 0);
      step();
      chk("rst_wr_no_ack2", wr_ack | wr_err | sw_done, 0);
      reset = 1'b0;
      model_reset();
      step();
      chk("rst_release_wr_ready", wr_ready, 1);
      chk("rst_active", active_ctx, 0);
      chk("rst_ctx_valid", ctx_valid, 0);
      chk_rdata("rst_r_data_ctx0");
      do_switch(3);
      do_switch(1);
      do_switch(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
